// File: rtl/pixel_write_sink_pkg.sv
// rtl/pixel_write_sink_pkg.sv - shared screen geometry and framebuffer entry types
package pixel_write_sink_pkg;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int FB_ADDR_W = 15;
  localparam int COLOUR_W  = 3;
  localparam int ENTRY_W   = FB_ADDR_W + COLOUR_W;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [COLOUR_W-1:0]  colour;
  } pixel_entry;

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - synchronous FIFO for buffered framebuffer writes
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // The caller only pushes into a full FIFO when it also pops that cycle.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);

endmodule

// File: rtl/pixel_write_sink.sv
// rtl/pixel_write_sink.sv - bounds-checks drawer pixel writes and streams them to the framebuffer
module pixel_write_sink
  import pixel_write_sink_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int SCREEN_W = pixel_write_sink_pkg::SCREEN_W,
  parameter int SCREEN_H = pixel_write_sink_pkg::SCREEN_H
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           vga_x,
  input  logic [6:0]           vga_y,
  input  logic [COLOUR_W-1:0]  vga_colour,
  input  logic                 vga_write,
  input  logic                 clear_flags,
  output logic                 fifo_full,
  output logic                 overflow,
  output logic [7:0]           dropped_count,
  output logic [FB_ADDR_W-1:0] mem_addr,
  output logic [COLOUR_W-1:0]  mem_data,
  output logic                 mem_we,
  input  logic                 mem_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [7:0] X_LIMIT = 8'(SCREEN_W);
  localparam logic [6:0] Y_LIMIT = 7'(SCREEN_H);

  logic                 in_bounds;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic [FB_ADDR_W-1:0] y_ext;
  pixel_entry           push_entry;
  pixel_entry           head_entry;

  assign in_bounds = (vga_x < X_LIMIT) && (vga_y < Y_LIMIT);

  // y*160 as two shifts so no multiplier is needed.
  assign y_ext      = {8'b0, vga_y};
  assign push_entry = '{addr:   (y_ext << 7) + (y_ext << 5) + {7'b0, vga_x},
                        colour: vga_colour};

  assign fifo_pop  = !fifo_empty && (!mem_we || mem_ready);
  assign fifo_push = vga_write && in_bounds && ((fifo_count < DEPTH_C) || fifo_pop);

  pixel_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else if (fifo_pop) begin
      mem_we   <= 1'b1;
      mem_addr <= head_entry.addr;
      mem_data <= head_entry.colour;
    end else if (mem_ready) begin
      mem_we   <= 1'b0;
    end
  end

  // clear_flags wins over a same-cycle increment or overflow event.
  always_ff @(posedge clock) begin
    if (reset || clear_flags) begin
      overflow      <= 1'b0;
      dropped_count <= '0;
    end else begin
      if (vga_write && in_bounds && !fifo_push) begin
        overflow <= 1'b1;
      end
      if (vga_write && !in_bounds && (dropped_count != 8'hff)) begin
        dropped_count <= dropped_count + 8'd1;
      end
    end
  end

endmodule
